// File: rtl/bit_packer.sv
// bit_packer: collects serial bits LSB-first into WIDTH-bit words,
// queues them in a DEPTH-entry FIFO and presents them on a valid/ready port.
// A flush pulse emits the current partial word, zero-padded in its upper bits.
module bit_packer #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    output logic             din_rdy,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] merged;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             push;
    logic [WIDTH-1:0] push_word;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;

    logic full;
    logic accept;
    logic last_bit;
    logic pop;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake and status terms, all derived from registered state
    assign full     = (occ == OW'(DEPTH));
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign din_rdy  = (state == ST_RUN) && !(full && last_bit);
    assign accept   = din_vld && din_rdy;
    assign dout_vld = (occ != '0);
    assign pop      = dout_vld && dout_rdy;
    assign dout     = mem[rd_ptr];
    assign busy     = (cnt != '0) || (state == ST_PEND) || dout_vld;

    // State register and assembly register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: bit assembly, word completion and flush handling
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        push      = 1'b0;
        push_word = shreg;
        merged    = shreg;
        if (accept) begin
            merged[cnt] = din;
        end
        case (state)
            ST_RUN: begin
                if (accept && last_bit) begin
                    push      = 1'b1;
                    push_word = {din, shreg[WIDTH-2:0]};
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                end else if (flush && (accept || (cnt != '0))) begin
                    if (!full) begin
                        push      = 1'b1;
                        push_word = merged;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_PEND;
                        shreg_nxt = merged;
                        cnt_nxt   = accept ? cnt + CW'(1) : cnt;
                    end
                end else if (accept) begin
                    shreg_nxt = merged;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            ST_PEND: begin
                // Pending partial word leaves on the first non-full cycle
                if (!full) begin
                    push      = 1'b1;
                    push_word = shreg;
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output FIFO: storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Testbench for bit_packer (WIDTH=2, DEPTH=2): directed vector table,
// reset sequence and randomized traffic against a queue-based reference model.
module tb_bit_packer;

    localparam int W = 2;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_vld;
    logic         din_rdy;
    logic         flush;
    logic [W-1:0] dout;
    logic         dout_vld;
    logic         dout_rdy;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending bits, queued words, pending-flush flag
    bit           m_bits[$];
    logic [W-1:0] m_fifo[$];
    bit           m_pend;

    bit_packer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .flush    (flush),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] w = '0;
        for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
        return w;
    endfunction

    function automatic bit m_full();
        return m_fifo.size() == D;
    endfunction

    function automatic bit m_rdy();
        return !m_pend && !(m_full() && m_bits.size() == W - 1);
    endfunction

    function automatic bit m_busy();
        return (m_bits.size() != 0) || m_pend || (m_fifo.size() != 0);
    endfunction

    // Compare DUT outputs to the model, then advance the model by one clock
    task automatic model_check_and_update(input logic v, input logic d, input logic f, input logic r);
        bit full_now;
        bit acc;
        chk("model_din_rdy", 32'(din_rdy), 32'(m_rdy()));
        chk("model_dout_vld", 32'(dout_vld), 32'(m_fifo.size() != 0));
        chk("model_busy", 32'(busy), 32'(m_busy()));
        if (m_fifo.size() != 0) chk("model_dout", 32'(dout), 32'(m_fifo[0]));
        full_now = m_full();
        acc = v && m_rdy();
        if (r && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (m_pend) begin
            if (!full_now) begin
                m_fifo.push_back(pack_bits());
                m_bits.delete();
                m_pend = 0;
            end
        end else begin
            if (acc) m_bits.push_back(d);
            if (m_bits.size() == W) begin
                m_fifo.push_back(pack_bits());
                m_bits.delete();
            end else if (f && m_bits.size() != 0) begin
                if (!full_now) begin
                    m_fifo.push_back(pack_bits());
                    m_bits.delete();
                end else begin
                    m_pend = 1;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic d, input logic f, input logic r);
        din_vld  = v;
        din      = d;
        flush    = f;
        dout_rdy = r;
        model_check_and_update(v, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_fifo.delete();
        m_pend = 0;
    endtask

    // Directed vectors: inputs for one cycle, outputs expected after that edge
    typedef struct packed {
        logic       v;
        logic       d;
        logic       f;
        logic       r;
        logic       e_rdy;
        logic       e_vld;
        logic [1:0] e_dout;
        logic       e_busy;
    } vec_t;

    vec_t vt[28];

    initial begin
        // v d f r _ rdy vld dout busy
        vt[0]  = 9'b1_1_0_1_1_0_00_1;  // bits 1,0 -> 2'b01
        vt[1]  = 9'b1_0_0_1_1_1_01_1;
        vt[2]  = 9'b1_0_0_1_1_0_00_1;  // bits 0,1 -> 2'b10
        vt[3]  = 9'b1_1_0_1_1_1_10_1;
        vt[4]  = 9'b0_0_0_1_1_0_00_0;
        vt[5]  = 9'b1_1_0_0_1_0_00_1;  // backpressure: 6 bits offered
        vt[6]  = 9'b1_1_0_0_1_1_11_1;
        vt[7]  = 9'b1_0_0_0_1_1_11_1;
        vt[8]  = 9'b1_1_0_0_1_1_11_1;
        vt[9]  = 9'b1_1_0_0_0_1_11_1;  // full, cnt=1 -> din_rdy low
        vt[10] = 9'b1_0_0_0_0_1_11_1;
        vt[11] = 9'b0_0_0_1_1_1_10_1;  // drain in order
        vt[12] = 9'b0_0_0_1_1_0_00_1;
        vt[13] = 9'b0_0_1_0_1_1_01_1;  // flush partial bit 1 -> 2'b01
        vt[14] = 9'b0_0_1_1_1_0_00_0;  // flush with cnt==0 ignored
        vt[15] = 9'b0_0_0_1_1_0_00_0;
        vt[16] = 9'b1_1_0_0_1_0_00_1;  // fill FIFO, then cnt=1
        vt[17] = 9'b1_0_0_0_1_1_01_1;
        vt[18] = 9'b1_0_0_0_1_1_01_1;
        vt[19] = 9'b1_0_0_0_1_1_01_1;
        vt[20] = 9'b1_1_0_0_0_1_01_1;
        vt[21] = 9'b0_0_1_0_0_1_01_1;  // flush while full -> pending
        vt[22] = 9'b0_0_1_0_0_1_01_1;  // extra flush absorbed
        vt[23] = 9'b0_0_0_1_0_1_00_1;  // single pop
        vt[24] = 9'b0_0_0_0_1_1_00_1;  // partial pushed, din_rdy back
        vt[25] = 9'b0_0_0_1_1_1_01_1;
        vt[26] = 9'b0_0_0_1_1_0_00_0;
        vt[27] = 9'b0_0_0_1_1_0_00_0;  // no second word from absorbed flush
    end

    initial begin
        rst = 1'b1;
        din = 1'b0;
        din_vld = 1'b0;
        flush = 1'b0;
        dout_rdy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_din_rdy", 32'(din_rdy), 32'd1);
        chk("reset_dout_vld", 32'(dout_vld), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 28; i++) begin
            step(vt[i].v, vt[i].d, vt[i].f, vt[i].r);
            chk($sformatf("vec%0d_din_rdy", i), 32'(din_rdy), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_dout_vld", i), 32'(dout_vld), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            if (vt[i].e_vld) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].e_dout));
        end

        // Reset mid-operation: 2 words queued (11, 00) and cnt=1
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_dout_vld", 32'(dout_vld), 32'd1);
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_rst_dout_vld", 32'(dout_vld), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_din_rdy", 32'(din_rdy), 32'd1);
        chk("async_rst_dout", 32'(dout), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("post_rst_no_stale", 32'(dout_vld), 32'd0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(9, 0) < 7),
                 1'($urandom_range(1, 0)),
                 1'($urandom_range(7, 0) == 0),
                 1'($urandom_range(9, 0) < 5));
        end
        // Drain and confirm the model and DUT settle idle together
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("final_busy", 32'(busy), 32'(m_busy()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
